fetcher: RTL and testbench
==========================

FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width.
REQ-002 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port core_state  input  3  scheduler state: FETCH=3'b001, DECODE=3'b010.
REQ-006 SHALL have port current_pc  input  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch.
REQ-007 SHALL have port mem_read_valid  output  1  read request to program memory.
REQ-008 SHALL have port mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read request address.
REQ-009 SHALL have port mem_read_ready  input  1  memory response strobe; read data is valid this cycle.
REQ-010 SHALL have port mem_read_data  input  PROGRAM_MEM_DATA_BITS  read data.
REQ-011 SHALL have port fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-012 SHALL have port instruction  output  PROGRAM_MEM_DATA_BITS  last fetched instruction, held stable.

Function
REQ-013 SHALL implement a three-state FSM (IDLE, FETCHING, FETCHED), with fetcher_state driven directly from the state register.
REQ-014 In IDLE with core_state==FETCH at a clock edge, SHALL set mem_read_valid=1, set mem_read_address=current_pc, and enter FETCHING on that edge.
REQ-015 In IDLE with any other core_state, SHALL hold all outputs unchanged.
REQ-016 In FETCHING, SHALL hold mem_read_valid=1 and mem_read_address constant until mem_read_ready=1 is sampled.
REQ-017 On the edge sampling mem_read_ready=1 in FETCHING, SHALL capture mem_read_data into instruction, clear mem_read_valid, and enter FETCHED.
REQ-018 Minimum miss latency SHALL be 2 edges from FETCH sampled to fetcher_state==FETCHED (ready returned on the first valid cycle).
REQ-019 In FETCHED with core_state==DECODE, SHALL return to IDLE on that edge; otherwise SHALL stay in FETCHED.
REQ-020 instruction SHALL change only on a capture (REQ-017 or REQ-027) and otherwise hold its value across all states.
REQ-021 SHALL ignore mem_read_ready outside FETCHING, with no state or output change.
REQ-022 SHALL never abort an in-flight request: if core_state leaves FETCH during FETCHING, the FSM SHALL still wait for ready.
REQ-023 The value of current_pc after the request is issued SHALL NOT affect mem_read_address.
REQ-024 Back-to-back fetches SHALL work: FETCHED -> IDLE on DECODE, then a new request on the next FETCH.

Reset
REQ-025 On reset==0, asynchronously and regardless of state, SHALL force FSM=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, and all cache valid bits=0 (when the cache is compiled in); a request in flight SHALL be dropped.
REQ-026 SHALL leave reset synchronously on the first rising clk edge with reset==1; no request SHALL be issued on that edge unless core_state==FETCH.

Configuration
REQ-027 With macro FETCHER_CACHE_EN defined, SHALL include a 4-entry direct-mapped instruction cache (index current_pc[1:0], tag = remaining PC bits, one valid bit per entry). In IDLE with core_state==FETCH and a hit, it SHALL load the cached word into instruction and go directly to FETCHED on that edge (1-edge latency) with mem_read_valid kept 0.
REQ-028 With FETCHER_CACHE_EN defined, on a miss SHALL behave per REQ-014..017, and on capture SHALL write the data, tag and valid bit into the indexed entry, replacing any previous entry.
REQ-029 Without FETCHER_CACHE_EN, SHALL contain no cache storage, and every fetch SHALL go to memory per REQ-014..017.

Verification
REQ-030 Basic fetch: reset, core_state=FETCH, current_pc=8'h05, ready one cycle after valid with data 16'h3A5C -> address=8'h05 while valid, instruction=16'h3A5C, fetcher_state=3'b010.
REQ-031 Stall: ready withheld 5 cycles, current_pc changed to 8'h09 during the stall -> valid and address=8'h05 held for all 5 cycles, single capture, no second request.
REQ-032 Handshake return: in FETCHED, hold core_state=DECODE for one cycle -> fetcher_state=3'b000 on the next edge, instruction unchanged.
REQ-033 Reset mid-fetch: assert reset=0 between clock edges while FETCHING -> valid=0, fetcher_state=0, instruction=0 immediately; a later stray ready has no effect.
REQ-034 Cache (FETCHER_CACHE_EN): fetch pc 8'h04 twice -> second fetch shows no mem_read_valid and FETCHED after 1 edge; then fetch pc 8'h08 (same index) and re-fetch 8'h04 -> both miss and go to memory.
REQ-035 Spurious ready: pulse mem_read_ready in IDLE and in FETCHED -> no state or instruction change.

Source files
------------

// File: rtl/fetcher.sv
// Instruction fetcher: issues one program-memory read per FETCH request and holds the result.
// Optional 4-entry direct-mapped instruction cache enabled with `define FETCHER_CACHE_EN.
module fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] FETCHING = 3'b001;
  localparam logic [2:0] FETCHED  = 3'b010;

  logic [2:0] state;
  logic       capture;
  logic       cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_word;

  assign fetcher_state = state;
  assign capture       = (state == FETCHING) && mem_read_ready;

`ifdef FETCHER_CACHE_EN
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - 2;

  logic [3:0]                       line_valid;
  logic [TAG_BITS-1:0]              line_tag  [4];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [4];
  logic [1:0]                       rd_index;
  logic [1:0]                       wr_index;

  assign rd_index = current_pc[1:0];
  assign wr_index = mem_read_address[1:0];

  always_comb begin
    cache_hit  = line_valid[rd_index] &&
                 (line_tag[rd_index] == current_pc[PROGRAM_MEM_ADDR_BITS-1:2]);
    cache_word = line_data[rd_index];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_valid <= '0;
    end else if (capture) begin
      line_valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (capture) begin
      line_tag[wr_index]  <= mem_read_address[PROGRAM_MEM_ADDR_BITS-1:2];
      line_data[wr_index] <= mem_read_data;
    end
  end
`else
  always_comb begin
    cache_hit  = 1'b0;
    cache_word = '0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (cache_hit) begin
              instruction <= cache_word;
              state       <= FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state            <= FETCHING;
            end
          end
        end
        FETCHING: begin
          // An in-flight request is never abandoned; only ready ends it.
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state          <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: begin
          state          <= IDLE;
          mem_read_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher; the cache scenario is compiled in with `define FETCHER_CACHE_EN.
module tb_fetcher;

  logic        clk;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int unsigned n_pass;
  int unsigned n_total;

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    core_state = 3'b000;
    current_pc = 8'h00;
    mem_read_ready = 1'b0;
    mem_read_data = 16'h0000;

    tick();
    tick();
    check("rst_state", fetcher_state, 3'b000);
    check("rst_valid", mem_read_valid, 1'b0);
    check("rst_addr", mem_read_address, 8'h00);
    check("rst_instr", instruction, 16'h0000);

    reset = 1'b1;
    tick();
    check("rel_state", fetcher_state, 3'b000);
    check("rel_valid", mem_read_valid, 1'b0);

    // Basic fetch, ready on first valid cycle
    core_state = 3'b001; current_pc = 8'h05;
    tick();
    check("req_valid", mem_read_valid, 1'b1);
    check("req_addr", mem_read_address, 8'h05);
    check("req_state", fetcher_state, 3'b001);
    mem_read_ready = 1'b1; mem_read_data = 16'h3A5C; core_state = 3'b000;
    tick();
    check("cap_state", fetcher_state, 3'b010);
    check("cap_instr", instruction, 16'h3A5C);
    check("cap_valid", mem_read_valid, 1'b0);

    // Spurious ready in FETCHED
    mem_read_data = 16'hFFFF;
    tick();
    check("spur_fd_state", fetcher_state, 3'b010);
    check("spur_fd_instr", instruction, 16'h3A5C);
    mem_read_ready = 1'b0;

    // Handshake return
    core_state = 3'b010;
    tick();
    check("dec_state", fetcher_state, 3'b000);
    check("dec_instr", instruction, 16'h3A5C);
    core_state = 3'b000;

    // Spurious ready in IDLE
    mem_read_ready = 1'b1; mem_read_data = 16'h1111;
    tick();
    check("spur_idle_state", fetcher_state, 3'b000);
    check("spur_idle_valid", mem_read_valid, 1'b0);
    check("spur_idle_instr", instruction, 16'h3A5C);
    mem_read_ready = 1'b0;

    // Stall: pc changes and FETCH drops while waiting
    do_reset();
    core_state = 3'b001; current_pc = 8'h05;
    tick();
    check("stall_req_state", fetcher_state, 3'b001);
    current_pc = 8'h09; core_state = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", mem_read_valid, 1'b1);
      check("stall_addr", mem_read_address, 8'h05);
      check("stall_state", fetcher_state, 3'b001);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    check("stall_cap_state", fetcher_state, 3'b010);
    check("stall_cap_instr", instruction, 16'hBEEF);
    mem_read_ready = 1'b0; core_state = 3'b001;
    tick();
    check("stall_no_req2", mem_read_valid, 1'b0);
    check("stall_hold_state", fetcher_state, 3'b010);
    core_state = 3'b010;
    tick();
    check("stall_dec", fetcher_state, 3'b000);

    // Back-to-back fetch
    core_state = 3'b001; current_pc = 8'h33;
    tick();
    check("b2b_addr", mem_read_address, 8'h33);
    mem_read_ready = 1'b1; mem_read_data = 16'h0F0F; core_state = 3'b000;
    tick();
    check("b2b_instr", instruction, 16'h0F0F);
    mem_read_ready = 1'b0;
    core_state = 3'b010;
    tick();
    core_state = 3'b000;

    // Reset mid-fetch between edges
    core_state = 3'b001; current_pc = 8'h22;
    tick();
    check("mid_req_state", fetcher_state, 3'b001);
    core_state = 3'b000;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", fetcher_state, 3'b000);
    check("mid_rst_valid", mem_read_valid, 1'b0);
    check("mid_rst_instr", instruction, 16'h0000);
    check("mid_rst_addr", mem_read_address, 8'h00);
    tick();
    reset = 1'b1;
    mem_read_ready = 1'b1; mem_read_data = 16'hABCD;
    tick();
    check("stray_state", fetcher_state, 3'b000);
    check("stray_instr", instruction, 16'h0000);
    check("stray_valid", mem_read_valid, 1'b0);
    mem_read_ready = 1'b0;

`ifdef FETCHER_CACHE_EN
    do_reset();
    core_state = 3'b001; current_pc = 8'h04;
    tick();
    check("c1_miss_valid", mem_read_valid, 1'b1);
    mem_read_ready = 1'b1; mem_read_data = 16'h1234; core_state = 3'b000;
    tick();
    mem_read_ready = 1'b0;
    check("c1_instr", instruction, 16'h1234);
    core_state = 3'b010;
    tick();
    core_state = 3'b001; current_pc = 8'h04;
    tick();
    check("c2_hit_state", fetcher_state, 3'b010);
    check("c2_hit_valid", mem_read_valid, 1'b0);
    check("c2_hit_instr", instruction, 16'h1234);
    core_state = 3'b010;
    tick();
    core_state = 3'b001; current_pc = 8'h08;
    tick();
    check("c3_miss_valid", mem_read_valid, 1'b1);
    check("c3_miss_addr", mem_read_address, 8'h08);
    mem_read_ready = 1'b1; mem_read_data = 16'h5678; core_state = 3'b000;
    tick();
    mem_read_ready = 1'b0;
    check("c3_instr", instruction, 16'h5678);
    core_state = 3'b010;
    tick();
    core_state = 3'b001; current_pc = 8'h04;
    tick();
    check("c4_miss_state", fetcher_state, 3'b001);
    check("c4_miss_valid", mem_read_valid, 1'b1);
    mem_read_ready = 1'b1; mem_read_data = 16'h1234; core_state = 3'b000;
    tick();
    mem_read_ready = 1'b0;
    check("c4_instr", instruction, 16'h1234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
